// File: rtl/trng_collector.sv
// Entropy collector: XOR-combines raw sources, synchronises, optionally Von Neumann debiases,
// runs a repetition-count health test and packs bits MSB-first into words behind a small FIFO.
module trng_collector #(
    parameter int OUT_W       = 32,
    parameter int N_SRC       = 3,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int RCT_LIMIT   = 32
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               en,
    input  logic [N_SRC-1:0]                   raw_in,
    input  logic                               debias_en,
    input  logic                               clear_fail,
    output logic [OUT_W-1:0]                   out_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
    output logic                               health_fail,
    output logic                               overflow
);
    localparam int LVL_W = $clog2(FIFO_DEPTH+1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(OUT_W);
    localparam int RUN_W = $clog2(RCT_LIMIT+1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OUT_W-1);
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(RCT_LIMIT);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    typedef enum logic {WAIT_FIRST, WAIT_SECOND} pair_state_t;

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   rs;
    pair_state_t            state_reg, state_next;
    logic                   first_reg, first_next;
    logic                   vld_reg, vld_next;
    logic                   bit_reg, bit_next;
    logic                   mode_reg, mode_next;
    logic                   prev_reg, prev_next;
    logic [RUN_W-1:0]       run_reg, run_next;
    logic                   hf_reg, hf_next;
    logic                   ovf_reg, ovf_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic [OUT_W-1:0]       shift_reg, shift_next;
    logic [OUT_W-1:0]       word;
    logic                   push, push_ok, pop, full;
    logic [PTR_W-1:0]       wr_ptr_reg, wr_ptr_next, rd_ptr_reg, rd_ptr_next;
    logic [LVL_W-1:0]       level_reg, level_next;
    logic [OUT_W-1:0]       mem [FIFO_DEPTH];

    assign rs          = sync_reg[SYNC_STAGES-1];
    assign word        = {shift_reg[OUT_W-2:0], bit_reg};
    assign out_valid   = (level_reg != '0);
    assign out_data    = out_valid ? mem[rd_ptr_reg] : '0;
    assign fifo_level  = level_reg;
    assign health_fail = hf_reg;
    assign overflow    = ovf_reg;
    assign pop         = out_valid & out_ready;
    assign full        = (level_reg == LVL_FULL);
    assign push_ok     = push & (~full | pop);

    always_comb begin
        state_next = state_reg;
        first_next = first_reg;
        vld_next   = vld_reg;
        bit_next   = bit_reg;
        mode_next  = mode_reg;
        prev_next  = prev_reg;
        run_next   = run_reg;
        hf_next    = hf_reg;
        ovf_next   = ovf_reg;
        cnt_next   = cnt_reg;
        shift_next = shift_reg;
        push       = 1'b0;
        if (en) begin
            vld_next  = 1'b0;
            mode_next = debias_en;
            // A mode switch restarts pairing so a pair never straddles two modes.
            if (debias_en != mode_reg) begin
                state_next = WAIT_FIRST;
            end else if (debias_en) begin
                case (state_reg)
                    WAIT_FIRST: begin
                        first_next = rs;
                        state_next = WAIT_SECOND;
                    end
                    default: begin
                        vld_next   = (rs != first_reg);
                        bit_next   = first_reg;
                        state_next = WAIT_FIRST;
                    end
                endcase
            end else begin
                vld_next   = 1'b1;
                bit_next   = rs;
                state_next = WAIT_FIRST;
            end

            prev_next = rs;
            if (rs == prev_reg)
                run_next = (run_reg == RUN_MAX) ? run_reg : run_reg + 1'b1;
            else
                run_next = RUN_W'(1);
            if (run_next == RUN_MAX)
                hf_next = 1'b1;

            // Bits arriving while the source is flagged unhealthy are never packed.
            if (hf_reg) begin
                cnt_next   = '0;
                shift_next = '0;
            end else if (vld_reg) begin
                shift_next = word;
                if (cnt_reg == CNT_LAST) begin
                    cnt_next = '0;
                    push     = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
        end
        if (push & full & ~pop)
            ovf_next = 1'b1;
        if (clear_fail) begin
            hf_next  = 1'b0;
            ovf_next = 1'b0;
            run_next = '0;
        end
    end

    always_comb begin
        wr_ptr_next = push_ok ? wr_ptr_reg + 1'b1 : wr_ptr_reg;
        rd_ptr_next = pop ? rd_ptr_reg + 1'b1 : rd_ptr_reg;
        case ({push_ok, pop})
            2'b10:   level_next = level_reg + 1'b1;
            2'b01:   level_next = level_reg - 1'b1;
            default: level_next = level_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg   <= '0;
            state_reg  <= WAIT_FIRST;
            first_reg  <= 1'b0;
            vld_reg    <= 1'b0;
            bit_reg    <= 1'b0;
            mode_reg   <= 1'b0;
            prev_reg   <= 1'b0;
            run_reg    <= '0;
            hf_reg     <= 1'b0;
            ovf_reg    <= 1'b0;
            cnt_reg    <= '0;
            shift_reg  <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            sync_reg   <= {sync_reg[SYNC_STAGES-2:0], ^raw_in};
            state_reg  <= state_next;
            first_reg  <= first_next;
            vld_reg    <= vld_next;
            bit_reg    <= bit_next;
            mode_reg   <= mode_next;
            prev_reg   <= prev_next;
            run_reg    <= run_next;
            hf_reg     <= hf_next;
            ovf_reg    <= ovf_next;
            cnt_reg    <= cnt_next;
            shift_reg  <= shift_next;
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            level_reg  <= level_next;
        end
    end

    // Storage needs no reset: out_data is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr_reg] <= word;
    end
endmodule

// File: tb/tb_trng_collector.sv
// Bench for trng_collector: randomized raw entropy against a queue-based behavioural model,
// plus directed checks of packing order, debiasing, health test, overflow, reset and enable.
module tb_trng_collector;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [2:0]  raw_in = '0;
    logic        debias_en = 1'b0;
    logic        clear_fail = 1'b0;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [2:0]  fifo_level;
    logic        health_fail;
    logic        overflow;

    int checks = 0;
    int failures = 0;
    int dut_pops = 0;

    always #5 clk = ~clk;

    trng_collector dut (
        .clk(clk), .rst_n(rst_n), .en(en), .raw_in(raw_in), .debias_en(debias_en),
        .clear_fail(clear_fail), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .fifo_level(fifo_level), .health_fail(health_fail),
        .overflow(overflow)
    );

    // Behavioural model: sampled stream -> emitted bits -> 32-bit words -> bounded queue.
    bit          q_sync[$];
    int          m_run;
    bit          m_prev, m_hf, m_ovf, m_pv, m_pb, m_have_first, m_first, m_mode;
    bit          m_bits[$];
    logic [31:0] exp_q[$];
    bit          mr_rs, mr_pop, mr_full, mr_push, mr_ovf_set;
    logic [31:0] mr_w;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                q_sync = '{1'b0, 1'b0};
                m_run = 0; m_prev = 0; m_hf = 0; m_ovf = 0; m_pv = 0; m_pb = 0;
                m_have_first = 0; m_first = 0; m_mode = 0;
                m_bits.delete(); exp_q.delete();
            end else begin
                mr_rs = q_sync[0];
                q_sync.pop_front();
                q_sync.push_back(^raw_in);
                mr_pop = (exp_q.size() != 0) && out_ready;
                mr_full = (exp_q.size() == 4);
                mr_push = 0; mr_ovf_set = 0;
                if (en) begin
                    if (m_hf) m_bits.delete();
                    else if (m_pv) begin
                        m_bits.push_back(m_pb);
                        if (m_bits.size() == 32) begin
                            for (int i = 0; i < 32; i++) mr_w[31-i] = m_bits[i];
                            m_bits.delete();
                            mr_push = 1;
                        end
                    end
                    m_run = (mr_rs == m_prev) ? ((m_run < 32) ? m_run + 1 : 32) : 1;
                    m_prev = mr_rs;
                    m_pv = 0;
                    if (debias_en != m_mode) m_have_first = 0;
                    else if (debias_en) begin
                        if (!m_have_first) begin m_first = mr_rs; m_have_first = 1; end
                        else begin m_pv = (mr_rs != m_first); m_pb = m_first; m_have_first = 0; end
                    end else begin
                        m_pv = 1; m_pb = mr_rs; m_have_first = 0;
                    end
                    m_mode = debias_en;
                end
                if (mr_pop) exp_q.pop_front();
                if (mr_push) begin
                    if (!mr_full || mr_pop) exp_q.push_back(mr_w);
                    else mr_ovf_set = 1;
                end
                if (clear_fail) begin m_hf = 0; m_ovf = 0; m_run = 0; end
                else begin
                    if (mr_ovf_set) m_ovf = 1;
                    if (en && m_run >= 32) m_hf = 1;
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model, taken just after each falling edge.
    initial begin
        forever begin
            @(negedge clk); #1;
            checks++;
            if (out_valid !== (exp_q.size() != 0)) begin
                failures++; $display("FAIL mon_valid t=%0t got=%b want=%b", $time, out_valid, exp_q.size() != 0);
            end
            checks++;
            if (fifo_level !== 3'(exp_q.size())) begin
                failures++; $display("FAIL mon_level t=%0t got=%0d want=%0d", $time, fifo_level, exp_q.size());
            end
            if (exp_q.size() != 0) begin
                checks++;
                if (out_data !== exp_q[0]) begin
                    failures++; $display("FAIL mon_data t=%0t got=%h want=%h", $time, out_data, exp_q[0]);
                end
            end
            checks++;
            if (health_fail !== m_hf) begin
                failures++; $display("FAIL mon_health t=%0t got=%b want=%b", $time, health_fail, m_hf);
            end
            checks++;
            if (overflow !== m_ovf) begin
                failures++; $display("FAIL mon_overflow t=%0t got=%b want=%b", $time, overflow, m_ovf);
            end
            if (out_valid && out_ready) dut_pops++;
        end
    end

    bit stim[$];

    task automatic drive_raw(input bit b);
        logic [2:0] r;
        r = 3'($urandom_range(0, 7));
        if ((^r) != b) r[0] = ~r[0];
        raw_in = r;
    endtask

    // Two priming cycles with en=0 fill the synchroniser, then stim[0..n-1] are sampled on n en cycles.
    task automatic play(input int n);
        for (int k = 0; k < n + 2; k++) begin
            @(negedge clk);
            en = (k >= 2);
            drive_raw((k < n) ? stim[k] : 1'($urandom_range(0, 1)));
        end
        @(negedge clk);
        en = 0;
        #1;
    endtask

    task automatic rand_stim(input int n);
        stim.delete();
        for (int i = 0; i < n; i++) stim.push_back(1'($urandom_range(0, 1)));
    endtask

    task automatic do_reset(input bit de);
        @(negedge clk);
        rst_n = 0; en = 0; clear_fail = 0; out_ready = 0; debias_en = de;
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_reset();
        do_reset(0);
        rst_n = 0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", out_valid); end
        checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d want=0", fifo_level); end
        checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL reset_data got=%h want=0", out_data); end
        checks++; if (health_fail !== 1'b0) begin failures++; $display("FAIL reset_health got=%b want=0", health_fail); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b want=0", overflow); end
        @(negedge clk);
        rst_n = 1;
        $display("test_reset done");
    endtask

    task automatic test_passthrough();
        do_reset(0);
        stim.delete();
        for (int i = 0; i < 33; i++) stim.push_back(1'((i + 1) % 2));
        play(33);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL pass_valid got=%b want=1", out_valid); end
        checks++; if (out_data !== 32'hAAAAAAAA) begin failures++; $display("FAIL pass_word got=%h want=aaaaaaaa", out_data); end
        checks++; if (fifo_level !== 3'd1) begin failures++; $display("FAIL pass_level got=%0d want=1", fifo_level); end
        $display("test_passthrough word=%h level=%0d", out_data, fifo_level);
    endtask

    task automatic test_debias();
        bit b;
        do_reset(1);
        stim.delete();
        stim.push_back(0);
        for (int g = 0; g < 32; g++) begin
            repeat ($urandom_range(0, 2)) begin
                b = 1'($urandom_range(0, 1));
                stim.push_back(b); stim.push_back(b);
            end
            stim.push_back(1); stim.push_back(0);
        end
        stim.push_back(0); stim.push_back(0);
        play(stim.size());
        checks++; if (out_data !== 32'hFFFFFFFF) begin failures++; $display("FAIL debias_word got=%h want=ffffffff", out_data); end
        checks++; if (fifo_level !== 3'd1) begin failures++; $display("FAIL debias_level got=%0d want=1", fifo_level); end
        $display("test_debias samples=%0d word=%h", stim.size(), out_data);
    endtask

    task automatic test_health();
        do_reset(0);
        stim.delete();
        for (int i = 0; i < 40; i++) stim.push_back(0);
        play(40);
        checks++; if (health_fail !== 1'b1) begin failures++; $display("FAIL health_set got=%b want=1", health_fail); end
        checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL health_nopush got=%0d want=0", fifo_level); end
        @(negedge clk); clear_fail = 1;
        @(negedge clk); clear_fail = 0; #1;
        checks++; if (health_fail !== 1'b0) begin failures++; $display("FAIL health_clear got=%b want=0", health_fail); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL health_clear_ovf got=%b want=0", overflow); end
        rand_stim(70);
        play(70);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL health_restart got=%b want=1", out_valid); end
        $display("test_health restart level=%0d", fifo_level);
    endtask

    task automatic test_overflow();
        int pops0;
        bit hit;
        do_reset(0);
        rand_stim(161);
        play(161);
        checks++; if (fifo_level !== 3'd4) begin failures++; $display("FAIL ovf_level got=%0d want=4", fifo_level); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b want=1", overflow); end
        pops0 = dut_pops;
        @(negedge clk); out_ready = 1;
        repeat (8) @(negedge clk);
        out_ready = 0; #1;
        checks++; if (dut_pops - pops0 !== 4) begin failures++; $display("FAIL ovf_drain got=%0d want=4", dut_pops - pops0); end
        @(negedge clk); clear_fail = 1;
        @(negedge clk); clear_fail = 0;
        hit = 0;
        for (int k = 0; k < 400 && !hit; k++) begin
            @(negedge clk);
            #2;
            en = 1;
            drive_raw(1'($urandom_range(0, 1)));
            hit = (exp_q.size() == 4) && (m_bits.size() == 31) && m_pv && !m_hf;
            out_ready = hit;
        end
        pops0 = dut_pops;
        @(negedge clk);
        out_ready = 0; en = 0; #2;
        checks++; if (!hit) begin failures++; $display("FAIL ovf_pushpop got=no_full_push want=full_push"); end
        checks++; if (fifo_level !== 3'd4) begin failures++; $display("FAIL ovf_pushpop_level got=%0d want=4", fifo_level); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_pushpop_flag got=%b want=0", overflow); end
        $display("test_overflow pushpop level=%0d overflow=%b", fifo_level, overflow);
    endtask

    task automatic test_reset_midword();
        logic [31:0] w;
        do_reset(0);
        rand_stim(53);
        play(53);
        #2 rst_n = 0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL arst_valid got=%b want=0", out_valid); end
        checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL arst_level got=%0d want=0", fifo_level); end
        checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL arst_data got=%h want=0", out_data); end
        @(negedge clk); @(negedge clk); rst_n = 1;
        rand_stim(32);
        for (int i = 0; i < 32; i++) w[31-i] = stim[i];
        play(32);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL arst_partial got=%b want=0", out_valid); end
        stim.delete(); stim.push_back(0); stim.push_back(1);
        play(2);
        checks++; if (out_data !== w) begin failures++; $display("FAIL arst_word got=%h want=%h", out_data, w); end
        $display("test_reset_midword word=%h", out_data);
    endtask

    task automatic test_en_pause();
        bit all_bits[$];
        logic [31:0] w;
        do_reset(0);
        rand_stim(45);
        all_bits = stim;
        play(45);
        out_ready = 1;
        repeat (10) begin
            @(negedge clk);
            drive_raw(1'($urandom_range(0, 1)));
        end
        out_ready = 0; #1;
        checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL pause_drain got=%0d want=0", fifo_level); end
        rand_stim(20);
        foreach (stim[i]) all_bits.push_back(stim[i]);
        play(20);
        for (int i = 0; i < 32; i++) w[31-i] = all_bits[32+i];
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL pause_valid got=%b want=1", out_valid); end
        checks++; if (out_data !== w) begin failures++; $display("FAIL pause_word got=%h want=%h", out_data, w); end
        $display("test_en_pause word=%h", out_data);
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_debias();
        test_health();
        test_overflow();
        test_reset_midword();
        test_en_pause();
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/trng_collector.md
Name: trng_collector

Overview:
- Parametrised successor of the single-word ring-oscillator random generator.
- Combines N_SRC external raw entropy bits and synchronises the result.
- Optionally debiases the stream with a Von Neumann corrector and runs a repetition-count health test.
- Packs bits into OUT_W-bit words and buffers them in a FIFO_DEPTH-entry FIFO with a valid/ready output handshake, so the entropy cores stay outside this block.

Parameters:
- OUT_W, 32: output word width in bits, >=2.
- N_SRC, 3: number of raw entropy inputs, XOR-combined.
- SYNC_STAGES, 2: synchroniser flop stages, >=2.
- FIFO_DEPTH, 4: output FIFO entries, power of 2, >=2.
- RCT_LIMIT, 32: consecutive identical samples that trip the health test, >=2.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- en  input  1  enable for sampling, debias, health test and collection.
- raw_in  input  N_SRC  asynchronous raw entropy bits.
- debias_en  input  1  1 = Von Neumann corrector on; 0 = raw passthrough.
- clear_fail  input  1  synchronous clear of health_fail and overflow.
- out_data  output  OUT_W  FIFO head word.
- out_valid  output  1  FIFO not empty.
- out_ready  input  1  consumer accepts out_data.
- fifo_level  output  $clog2(FIFO_DEPTH+1)  FIFO occupancy.
- health_fail  output  1  sticky repetition-count failure.
- overflow  output  1  sticky: a completed word was dropped.

Behaviour:
- Reset: clk and rst_n are as already decided (rst_n asynchronous, active-low). All flops go to 0: sync chain, pair FSM in WAIT_FIRST, run counter, bit counter, shift register, FIFO pointers. out_data=0, out_valid=0, fifo_level=0, health_fail=0, overflow=0. Reset mid-word discards the partial word.
- Sync: s = XOR of raw_in, through SYNC_STAGES flops clocked every cycle regardless of en. rs = last stage.
- en=0 freezes the pair FSM, run counter, bit counter and shift register. The FIFO still drains.
- Pair FSM, when en=1 and debias_en=1:
  - WAIT_FIRST: latch first=rs, go to WAIT_SECOND.
  - WAIT_SECOND: if rs!=first, emit bit=first with vld=1 on the next cycle; in all cases go to WAIT_FIRST.
- Passthrough, when en=1 and debias_en=0: emit bit=rs with vld=1 on the next cycle, every en cycle. The pair FSM is held in WAIT_FIRST.
- A change of debias_en between consecutive cycles forces the pair FSM to WAIT_FIRST. No bit is emitted that cycle.
- vld/bit are registered outputs of the debias stage. vld defaults to 0 each en cycle.
- Health test (every en cycle, on rs):
  - If rs equals the previous sample, run++ (saturating); else run=1.
  - When run reaches RCT_LIMIT, health_fail is set. It is sticky.
- While health_fail=1: vld bits are discarded, and the bit counter and shift register are held at 0. FIFO contents remain readable.
- clear_fail=1 clears health_fail, overflow and run in the same cycle. It has priority over a simultaneous set.
- Collector, on an en cycle with vld=1 and health_fail=0:
  - shift = {shift[OUT_W-2:0], bit}, so the first bit collected ends up as the MSB.
  - cnt++.
  - When cnt==OUT_W-1, the word {shift[OUT_W-2:0], bit} is pushed to the FIFO at that edge, and cnt wraps to 0.
- Latency: out_valid rises on the edge after the push if the FIFO was empty.
- FIFO:
  - Pop when out_valid & out_ready.
  - A push is accepted if not full, or if a pop occurs in the same cycle; in the latter case fifo_level is unchanged.
  - A push while full with no pop drops the new word and sets overflow. Existing contents are unchanged.
  - out_data is the head entry, stable while out_valid=1 and out_ready=0.
  - Order is FIFO; pointers wrap modulo FIFO_DEPTH.

Test Plan:
- Default params, debias_en=0, en=1, rs alternating 1,0,1,0… -> first word 0xAAAAAAAA, out_valid high 1 cycle after the 32nd vld, fifo_level=1.
- debias_en=1, rs pairs (1,0) repeated 32 times -> one word 0xFFFFFFFF after 64 en cycles. Pairs (0,0)/(1,1) produce no bits.
- raw_in held at 0, en=1 -> health_fail=1 once run reaches 32, no word pushed. Then clear_fail pulse -> health_fail=0, overflow=0, collection restarts from cnt=0.
- out_ready=0 while 5 words complete -> fifo_level=4, overflow=1. Then out_ready=1 -> words 1-4 delivered in order, word 5 lost. Push coinciding with a pop while full -> accepted, level stays 4.
- rst_n asserted after 20 bits collected -> all outputs 0 immediately (asynchronous). After release, next word needs 32 fresh bits.
- en=0 for 10 cycles mid-word -> cnt/shift frozen, FIFO drains with out_ready=1. Resume completes the same word with no lost or duplicated bits.
